// File: rtl/mac_dot_feeder_if.sv
// Operand-buffer read port, MAC drive/observe port and result handshake
// shared by one feeder and its surroundings.
interface mac_dot_feeder_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 2 * DATA_WIDTH,
  parameter int ADDR_WIDTH  = 2
);
  logic                          rd_en;
  logic [ADDR_WIDTH-1:0]         rd_addr;
  logic signed [DATA_WIDTH-1:0]  rd_a;
  logic signed [DATA_WIDTH-1:0]  rd_b;

  logic                          mac_clr;
  logic                          mac_running;
  logic signed [DATA_WIDTH-1:0]  mac_in1;
  logic signed [DATA_WIDTH-1:0]  mac_in2;
  logic signed [ACCUM_WIDTH-1:0] mac_total;
  logic                          mac_err;

  logic                          res_valid;
  logic                          res_ready;
  logic signed [ACCUM_WIDTH-1:0] res_data;
  logic                          res_err;

  modport master (
    output rd_en, rd_addr,
    input  rd_a, rd_b,
    output mac_clr, mac_running,
    output mac_in1, mac_in2,
    input  mac_total, mac_err,
    output res_valid, res_data, res_err,
    input  res_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_a, rd_b,
    input  mac_clr, mac_running,
    input  mac_in1, mac_in2,
    output mac_total, mac_err,
    input  res_valid, res_data, res_err,
    output res_ready
  );
endinterface

// File: rtl/mac_dot_feeder.sv
// Per-MAC sequencer: clears the MAC, streams L operand pairs from the
// buffer, waits out the MAC latency and hands back total/err.
module mac_dot_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 2 * DATA_WIDTH,
  parameter int DIM         = 4,
  parameter int ADDR_WIDTH  = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(DIM+1)-1:0] len,
  output logic                     busy,
  mac_dot_feeder_if.master         bus
);
  localparam int LW = $clog2(DIM + 1);

  typedef enum logic [2:0] {
    IDLE, CLR, FEED, DRAIN, HOLD
  } state_t;

  state_t state, nxt;

  logic [LW-1:0]                 len_q;
  logic [ADDR_WIDTH-1:0]         idx;
  logic [1:0]                    dcnt;
  logic                          rd_v;
  logic                          run_q;
  logic signed [DATA_WIDTH-1:0]  in1_q;
  logic signed [DATA_WIDTH-1:0]  in2_q;
  logic signed [ACCUM_WIDTH-1:0] res_q;
  logic                          err_q;
  logic                          vld_q;
  logic                          last_rd;
  logic                          last_dr;
  logic                          xfer;

  assign last_rd = (LW'(idx) + LW'(1)) == len_q;
  assign last_dr = dcnt == 2'd2;
  assign xfer    = vld_q && bus.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = CLR;
      CLR:     nxt = (len_q == '0) ? DRAIN : FEED;
      FEED:    if (last_rd) nxt = DRAIN;
      DRAIN:   if (last_dr) nxt = HOLD;
      HOLD:    if (xfer) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      idx   <= '0;
      dcnt  <= '0;
      rd_v  <= 1'b0;
      run_q <= 1'b0;
      in1_q <= '0;
      in2_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      // rd_v marks read data on rd_a/rd_b; run_q is the operand stage valid
      rd_v  <= state == FEED;
      run_q <= rd_v;
      if (rd_v) begin
        in1_q <= bus.rd_a;
        in2_q <= bus.rd_b;
      end
      if (state == IDLE && start)
        len_q <= (len > LW'(DIM)) ? LW'(DIM) : len;
      if (state == CLR)
        idx <= '0;
      else if (state == FEED && !last_rd)
        idx <= idx + ADDR_WIDTH'(1);
      if (state == DRAIN) dcnt <= dcnt + 2'd1;
      else                dcnt <= '0;
      if (state == DRAIN && last_dr) begin
        res_q <= bus.mac_total;
        err_q <= bus.mac_err;
        vld_q <= 1'b1;
      end else if (xfer) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign busy            = state != IDLE;
  assign bus.rd_en       = state == FEED;
  assign bus.rd_addr     = idx;
  assign bus.mac_clr     = state == CLR;
  assign bus.mac_running = run_q;
  assign bus.mac_in1     = in1_q;
  assign bus.mac_in2     = in2_q;
  assign bus.res_valid   = vld_q;
  assign bus.res_data    = res_q;
  assign bus.res_err     = err_q;
endmodule

// File: tb/tb_mac_dot_feeder.sv
// Bench for mac_dot_feeder: behavioural operand buffer and MAC, directed
// jobs, timing checks in the driver and a result scoreboard.
module tb_mac_dot_feeder;
  localparam int DIM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] len;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int job      = 0;
  int ms;

  logic [16:0]             exp_q[$];
  logic signed [7:0]       mem_a[DIM];
  logic signed [7:0]       mem_b[DIM];

  mac_dot_feeder_if #(
    .DATA_WIDTH(8), .ACCUM_WIDTH(16), .ADDR_WIDTH(2)
  ) bus ();

  mac_dot_feeder #(
    .DATA_WIDTH(8), .ACCUM_WIDTH(16), .DIM(DIM), .ADDR_WIDTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .len(len), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  // synchronous-read operand buffer
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_a <= '0;
      bus.rd_b <= '0;
    end else if (bus.rd_en) begin
      bus.rd_a <= mem_a[bus.rd_addr];
      bus.rd_b <= mem_b[bus.rd_addr];
    end
  end

  // MAC: 16-bit wrapping accumulator with sticky signed overflow
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mac_total <= '0;
      bus.mac_err   <= 1'b0;
    end else if (bus.mac_clr) begin
      bus.mac_total <= '0;
      bus.mac_err   <= 1'b0;
    end else if (bus.mac_running) begin
      ms = int'(bus.mac_total) + int'(bus.mac_in1) * int'(bus.mac_in2);
      bus.mac_total <= 16'(ms);
      if (ms > 32767 || ms < -32768) bus.mac_err <= 1'b1;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL job%0d %s: got %0d expected %0d", job, nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {24'd0, busy, bus.rd_en, bus.mac_clr, bus.mac_running,
            bus.res_valid, bus.res_err, bus.rd_addr,
            bus.mac_in1, bus.mac_in2, bus.res_data};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", longint'(bus.res_data), -1);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", longint'(bus.res_data), longint'($signed(e[15:0])));
        chk("res_err", longint'(bus.res_err), longint'(e[16]));
      end
    end
  end

  task automatic load(input int a0, a1, a2, a3, b0, b1, b2, b3);
    mem_a[0] = 8'(a0); mem_a[1] = 8'(a1);
    mem_a[2] = 8'(a2); mem_a[3] = 8'(a3);
    mem_b[0] = 8'(b0); mem_b[1] = 8'(b1);
    mem_b[2] = 8'(b2); mem_b[3] = 8'(b3);
  endtask

  // Called at posedge+1 of cycle 0; drives one job and checks its timing.
  task automatic run_job(input int ln, input int hold, input bit poke,
                         input int ed, input logic ee);
    int l, clr_c, frd, nrd, abad, frun, lrun, nrun, fvld, done, unst;
    logic signed [15:0] held;
    job++;
    l = (ln > DIM) ? DIM : ln;
    clr_c = -1; frd = -1; nrd = 0; abad = 0; frun = -1; lrun = -1;
    nrun = 0; fvld = -1; done = -1; unst = 0; held = '0;
    exp_q.push_back({ee, 16'(ed)});
    start = 1'b1;
    len   = 3'(ln);
    @(posedge clk); #1;
    start = 1'b0;
    len   = 3'd1;
    for (int c = 1; c <= 80 && done < 0; c++) begin
      if (bus.mac_clr && clr_c < 0) clr_c = c;
      if (bus.rd_en) begin
        if (int'(bus.rd_addr) != nrd) abad++;
        if (frd < 0) frd = c;
        nrd++;
      end
      if (bus.mac_running) begin
        if (frun < 0) frun = c;
        lrun = c;
        nrun++;
      end
      if (bus.res_valid) begin
        if (fvld < 0) begin
          fvld = c;
          held = bus.res_data;
        end else if (bus.res_data != held || bus.mac_running) begin
          unst++;
        end
      end
      start = poke && (c == 3 || c == l + 6);
      bus.res_ready = fvld >= 0 && c >= fvld + hold;
      if (bus.res_valid && bus.res_ready) done = c;
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b0;
    start = 1'b0;
    chk("xfer_seen", longint'(done >= 0), 1);
    chk("clr_cycle", clr_c, 1);
    chk("rd_first", frd, l > 0 ? 2 : -1);
    chk("rd_count", nrd, l);
    chk("rd_addr_seq", abad, 0);
    chk("run_first", frun, l > 0 ? 4 : -1);
    chk("run_last", lrun, l > 0 ? l + 3 : -1);
    chk("run_count", nrun, l);
    chk("valid_cycle", fvld, l + 5);
    chk("hold_stable", unst, 0);
    chk("busy_after", longint'(busy), 0);
    chk("valid_after", longint'(bus.res_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len   = '0;
    bus.res_ready = 1'b0;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", longint'(outs()), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    load(1, 2, 3, 4, 1, 1, 1, 1);
    run_job(4, 0, 1'b0, 10, 1'b0);
    run_job(4, 6, 1'b0, 10, 1'b0);

    load(-128, -128, 0, 0, -128, -128, 0, 0);
    run_job(2, 1, 1'b0, -32768, 1'b1);
    load(127, 127, 127, 0, 127, 127, 127, 0);
    run_job(3, 0, 1'b0, -17149, 1'b1);
    load(1, 0, 0, 0, 1, 0, 0, 0);
    run_job(1, 0, 1'b0, 1, 1'b0);

    run_job(0, 0, 1'b0, 0, 1'b0);
    load(1, 2, 3, 4, 2, 2, 2, 2);
    run_job(DIM + 3, 0, 1'b0, 20, 1'b0);

    load(1, -2, 3, -4, 5, 5, 5, 5);
    run_job(4, 3, 1'b1, -10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("poke_idle", longint'(busy), 0);

    // abort a job in its third cycle (FEED) with reset
    job++;
    load(9, 9, 9, 9, 9, 9, 9, 9);
    start = 1'b1;
    len   = 3'd4;
    repeat (3) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_abort_rd_en", longint'(bus.rd_en), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", longint'(outs()), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(5, 0, 0, 0, -3, 0, 0, 0);
    run_job(1, 0, 1'b0, -15, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_dot_feeder.md
# mac_dot_feeder

Sequencer that drives one MAC instance to compute a signed dot product of length `len`. It reads operand pairs from a synchronous-read operand buffer and clears the MAC before each job. It streams pairs into the MAC's `in1`/`in2`/`running` inputs, waits out the MAC update latency, then returns the MAC's `total` and `err` through a valid/ready result port. It sits between the operand buffers and the MAC array of the matrix multiplier: one feeder per MAC.

## Interface
- `DATA_WIDTH`, 8: operand width, signed.
- `ACCUM_WIDTH`, 2*DATA_WIDTH: MAC accumulator width.
- `DIM`, 4: maximum dot-product length, at least 1.
- `ADDR_WIDTH`, $clog2(DIM) (minimum 1): operand buffer address width.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  $clog2(DIM+1)  products in job; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `rd_en`  out  1  operand buffer read strobe.
- `rd_addr`  out  ADDR_WIDTH  operand index.
- `rd_a`, `rd_b`  in  DATA_WIDTH signed  operands; valid the cycle after `rd_en`.
- `mac_clr`  out  1  synchronous clear to the MAC.
- `mac_running`  out  1  MAC accumulate enable.
- `mac_in1`, `mac_in2`  out  DATA_WIDTH signed  MAC operands.
- `mac_total`  in  ACCUM_WIDTH signed  MAC accumulator. It updates the edge after `mac_running` is sampled high.
- `mac_err`  in  1  sticky MAC overflow flag.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  ACCUM_WIDTH signed  captured `mac_total`.
- `res_err`  out  1  captured `mac_err`.

## Operation
- Effective length `L` = min(`len`, DIM), latched at start.
- State machine: IDLE -> CLR -> FEED -> DRAIN -> HOLD -> IDLE.
- IDLE: `start`=1 latches `L` and moves to CLR.
- CLR: one cycle with `mac_clr`=1.
  - If L=0, go to DRAIN.
  - Otherwise go to FEED.
- FEED: L cycles. Each cycle asserts `rd_en`=1 with `rd_addr` = 0, 1, ..., L-1. The last index moves to DRAIN.
- Operand pipeline: one register stage.
  - `mac_in1`/`mac_in2` <= `rd_a`/`rd_b` on the edge after each read returns.
  - `mac_running` is the registered valid bit of that stage: high exactly L cycles, contiguous.
- DRAIN: fixed 3 cycles covering read return, MAC accumulate and total settle.
  - On the final DRAIN edge, `res_data` <= `mac_total`, `res_err` <= `mac_err`, and `res_valid` <= 1.
  - Enter HOLD.
- HOLD:
  - `res_valid`=1; `res_data`/`res_err` stay stable until `res_ready`=1.
  - On `res_valid`&&`res_ready`, clear `res_valid` and return to IDLE.
  - `mac_running`=0 throughout, so the MAC total holds.
- No arithmetic is performed here; results are MAC values passed through unchanged. `res_err`=1 means the MAC's signed overflow flag was set during the job.
- `mac_in1`/`mac_in2` hold their last value when `mac_running`=0.

## Timing
- Reset (async, `rst_n`=0): state IDLE.
- Reset values: `busy`, `rd_en`, `mac_clr`, `mac_running`, `res_valid` and `res_err` all 0; `rd_addr`, `mac_in1`, `mac_in2` and `res_data` all 0.
- Reset mid-job aborts immediately with the same values; no partial result is emitted.
- Cycle numbering, with `start` sampled at end of cycle 0:
  - CLR in cycle 1.
  - FEED in cycles 2..L+1.
  - `mac_running` high in cycles 4..L+3.
  - DRAIN in cycles L+2..L+4.
  - `res_valid` first high in cycle L+5.
- For L=0: CLR in cycle 1, DRAIN in cycles 2..4, `res_valid` in cycle 5; `rd_en` and `mac_running` never assert.
- `start` while busy is ignored, and `len` changes mid-job have no effect.
- Result transfer occurs in the cycle where `res_valid` and `res_ready` are both 1. IDLE follows, so the next `start` is accepted one cycle after the transfer at the earliest.
- `busy` is 1 from cycle 1 through the transfer cycle.
- `res_ready` high before `res_valid` has no effect.

## Test plan
- L=4, a={1,2,3,4}, b={1,1,1,1}, `res_ready`=1 -> `rd_en` cycles 2-5; `mac_running` cycles 4-7; `res_valid` cycle 9; `res_data`=10, `res_err`=0.
- Same job with `res_ready` held 0 for 6 cycles -> `res_valid`, `res_data`=10 and `mac_running`=0 stable throughout; transfer on the first `res_ready`=1; `busy` drops next cycle.
- L=2, a={-128,-128}, b={-128,-128} -> `res_err`=1. Then L=3, a=b={127,127,127} -> `res_err`=1. A following job with a=b={1} -> `res_err`=0, `res_data`=1 (CLR cleared the MAC).
- `len`=0 -> no `rd_en`; `mac_clr` cycle 1; `res_valid` cycle 5; `res_data`=0. `len`=DIM+3 -> exactly DIM reads, addresses 0..DIM-1.
- `start` pulsed during FEED and HOLD -> ignored; only one result is produced.
- `rst_n` dropped in FEED cycle 3 -> all outputs 0 asynchronously; after release, an L=1 job with a=5, b=-3 -> `res_data`=-15 in cycle 6.
